// File: rtl/go_kill_pkg.sv
// Shared state encoding for the go/kill run-timer.
package go_kill_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    ABORT  = 2'b10,
    FINISH = 2'b11
  } state_t;
endpackage

// File: rtl/go_kill_timer_if.sv
// Control/status bundle of the go/kill run-timer; master drives requests, slave is the timer.
interface go_kill_timer_if import go_kill_pkg::*; #(
  parameter int CNT_W = 8
);
  logic               go;
  logic               kill;
  logic               hold;
  logic [CNT_W-1:0]   limit;
  logic               done;
  logic               aborted;
  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] state;

  modport master (output go, kill, hold, limit,
                  input  done, aborted, busy, cnt, state);
  modport slave  (input  go, kill, hold, limit,
                  output done, aborted, busy, cnt, state);
endinterface

// File: rtl/go_kill_cnt.sv
// Run counter: sync clear beats enable; tc flags cnt reaching the latched limit.
module go_kill_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit_q,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk) begin
    if (reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == limit_q);
endmodule

// File: rtl/go_kill_timer.sv
// Go/kill run-timer: go launches a run of limit+1 ACTIVE cycles, kill aborts it.
// GO_KILL_AUTORELOAD_EN lets a go seen in FINISH relaunch without an IDLE gap.
module go_kill_timer import go_kill_pkg::*; #(
  parameter int CNT_W     = 8,
  parameter int DEF_LIMIT = 100,
  parameter bit USE_DEF   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  go_kill_timer_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] limit_q, sel_limit, cnt;
  logic             launch, clr, en, tc;
  logic             done_q, aborted_q, busy_q;

  assign sel_limit = (USE_DEF && bus.limit == '0) ? DEF_L : bus.limit;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE:   if (bus.go && !bus.kill) begin
                state_d = ACTIVE;
                launch  = 1'b1;
              end
      // kill is checked before terminal count
      ACTIVE: if (bus.kill)              state_d = ABORT;
              else if (!bus.hold && tc)  state_d = FINISH;
      ABORT:  if (!bus.kill)             state_d = IDLE;
      FINISH: begin
        state_d = IDLE;
`ifdef GO_KILL_AUTORELOAD_EN
        if (bus.go && !bus.kill) begin
          state_d = ACTIVE;
          launch  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // cnt is zero everywhere except ACTIVE and FINISH (which keeps the final value)
    clr = launch || (state_d == IDLE) || (state_d == ABORT);
    en  = (state_q == ACTIVE) && (state_d == ACTIVE) && !bus.hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (launch) limit_q <= sel_limit;
      done_q    <= (state_d == FINISH);
      aborted_q <= (state_d == ABORT) && (state_q != ABORT);
      busy_q    <= (state_d == ACTIVE) || (state_d == ABORT);
    end
  end

  go_kill_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .en      (en),
    .limit_q (limit_q),
    .cnt     (cnt),
    .tc      (tc)
  );

  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.busy    = busy_q;
  assign bus.cnt     = cnt;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_go_kill_timer.sv
// Directed bench: dut_a uses the default limit substitution, dut_b has USE_DEF=0.
module tb_go_kill_timer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef GO_KILL_AUTORELOAD_EN
  localparam int AR_PER = 3;
`else
  localparam int AR_PER = 4;
`endif

  always #5 clk = ~clk;

  go_kill_timer_if #(.CNT_W(8)) ifa ();
  go_kill_timer_if #(.CNT_W(8)) ifb ();

  go_kill_timer #(.CNT_W(8), .DEF_LIMIT(100), .USE_DEF(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  go_kill_timer #(.CNT_W(8), .DEF_LIMIT(100), .USE_DEF(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run and count edges after the go-sampling edge until done shows.
  task automatic run_lat(input bit sel_b, input logic [7:0] lim, input int max, output int k);
    if (sel_b) begin ifb.limit = lim; ifb.go = 1'b1; end
    else       begin ifa.limit = lim; ifa.go = 1'b1; end
    tick();
    ifa.go = 1'b0;
    ifb.go = 1'b0;
    k = 0;
    while (!(sel_b ? ifb.done : ifa.done) && k <= max) begin
      tick();
      k++;
    end
    tick();
    chk("done_single", sel_b ? ifb.done : ifa.done, 0);
  endtask

  initial begin
    int k, nd, t0, t1, t2;
    {ifa.go, ifa.kill, ifa.hold, ifa.limit} = '0;
    {ifb.go, ifb.kill, ifb.hold, ifb.limit} = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", ifa.state, 0);
    chk("rst_cnt", ifa.cnt, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_abort", ifa.aborted, 0);

    // normal run, limit 3: cnt 0..3, done one cycle
    ifa.limit = 8'd3; ifa.go = 1'b1;
    tick();
    ifa.go = 1'b0;
    chk("run_state", ifa.state, 1);
    chk("run_busy", ifa.busy, 1);
    chk("run_cnt0", ifa.cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("run_cnt", ifa.cnt, i);
      chk("run_nodone", ifa.done, 0);
    end
    tick();
    chk("run_done", ifa.done, 1);
    chk("run_fin", ifa.state, 3);
    chk("run_fincnt", ifa.cnt, 3);
    tick();
    chk("run_done_off", ifa.done, 0);
    chk("run_idle", ifa.state, 0);
    chk("run_idlecnt", ifa.cnt, 0);

    // limit 0: DEF_LIMIT on dut_a, one-cycle run on dut_b; then max limit
    run_lat(1'b0, 8'd0, 200, k);   chk("def_lat", k, 101);
    run_lat(1'b1, 8'd0, 200, k);   chk("zero_lat", k, 1);
    run_lat(1'b1, 8'd255, 400, k); chk("max_lat", k, 256);

    // go with kill in IDLE is ignored
    ifa.go = 1'b1; ifa.kill = 1'b1;
    tick();
    chk("gokill_idle", ifa.state, 0);
    ifa.go = 1'b0; ifa.kill = 1'b0;

    // kill on the terminal-count cycle, held three cycles, go during ABORT
    ifa.limit = 8'd4; ifa.go = 1'b1;
    tick();
    ifa.go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("kill_cnt4", ifa.cnt, 4);
    ifa.kill = 1'b1;
    tick();
    chk("kill_state", ifa.state, 2);
    chk("kill_abort", ifa.aborted, 1);
    chk("kill_nodone", ifa.done, 0);
    chk("kill_cnt", ifa.cnt, 0);
    chk("kill_busy", ifa.busy, 1);
    ifa.go = 1'b1;
    tick();
    chk("abort_once", ifa.aborted, 0);
    chk("abort_stay", ifa.state, 2);
    tick();
    chk("abort_stay2", ifa.state, 2);
    chk("abort_nodone", ifa.done, 0);
    ifa.kill = 1'b0;
    tick();
    chk("abort_exit", ifa.state, 0);
    chk("abort_exit_busy", ifa.busy, 0);
    ifa.go = 1'b0;
    tick();

    // hold 5 cycles at cnt=1 and a limit change mid-run
    ifa.limit = 8'd2; ifa.go = 1'b1;
    tick();
    ifa.go = 1'b0;
    ifa.limit = 8'd9;
    tick();
    chk("hold_cnt1", ifa.cnt, 1);
    ifa.hold = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_frozen", ifa.cnt, 1);
    chk("hold_state", ifa.state, 1);
    ifa.hold = 1'b0;
    k = 6;
    while (!ifa.done && k <= 20) begin
      tick();
      k++;
    end
    chk("hold_lat", k, 8);
    tick();

    // reset mid-run at cnt=5
    ifa.limit = 8'd10; ifa.go = 1'b1;
    tick();
    ifa.go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_cnt5", ifa.cnt, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_state", ifa.state, 0);
    chk("mid_cnt", ifa.cnt, 0);
    chk("mid_busy", ifa.busy, 0);
    chk("mid_done", ifa.done, 0);
    chk("mid_abort", ifa.aborted, 0);

    // go held high, limit 1: done period depends on autoreload
    ifa.limit = 8'd1; ifa.go = 1'b1;
    nd = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ifa.done) begin
        if (nd == 0)      t0 = i;
        else if (nd == 1) t1 = i;
        else if (nd == 2) t2 = i;
        nd++;
      end
    end
    chk("ar_first", t0, 2);
    chk("ar_per1", t1 - t0, AR_PER);
    chk("ar_per2", t2 - t1, AR_PER);
    ifa.go = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ar_idle", ifa.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
